// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio mixer/scheduler slice.
// Holds the scheduler FSM encoding, the PCM sample width and the
// midscale helper used for the DAC idle/reset code.
package audio_pkg;

  // Width of every voice sample and of the saturated mix.
  localparam int SAMPLE_W = 16;

  // Mix scheduler phases: wait for a sample tick, walk the channels,
  // saturate/scale, register the PCM word, strobe the DAC.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_SCALE   = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_STROBE  = 3'd4
  } state_t;

  // Offset-binary code for 0.0 at a given DAC width (only the lowest
  // 'bitdepth' bits are meaningful to the caller).
  function automatic logic [SAMPLE_W-1:0] midscale(input int bitdepth);
    return SAMPLE_W'(1) << (bitdepth - 1);
  endfunction

endpackage

// File: rtl/audio_sat16.sv
// Combinational saturation of the wide signed mix accumulator into the
// signed 16-bit range [-32768, 32767].
module audio_sat16
  import audio_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [SAMPLE_W-1:0] sat
);

  logic pos_ovf;
  logic neg_ovf;

  // Overflow whenever the bits above the 16-bit sign do not all match it.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path (here a default up front) so no latch is inferred.
    pos_ovf = !acc[ACC_W-1] && (|acc[ACC_W-2:SAMPLE_W-1]);
    neg_ovf = acc[ACC_W-1] && !(&acc[ACC_W-2:SAMPLE_W-1]);
    sat     = acc[SAMPLE_W-1:0];
    if (pos_ovf) begin
      sat = 16'sh7FFF;
    end else if (neg_ovf) begin
      sat = 16'sh8000;
    end
  end

endmodule

// File: rtl/audio_mix_sched.sv
// Audio mixer / DAC sample scheduler.
// A period counter produces one tick every max(div, NCHAN+3)+1 clocks. Each
// tick walks the voice channels one per cycle, accumulates accepted
// samples, saturates the mix to 16 bits, registers an offset-binary PCM
// word and strobes sample_clock one cycle later (tick-to-strobe latency is
// NCHAN+3 cycles). Enabled channels with no sample pending count as
// underruns in a saturating 8-bit counter.
// Optional feature: define AUDIO_MASTER_VOL_EN to add the master_vol input,
// which scales the saturated mix by master_vol/256 in the SCALE phase.
module audio_mix_sched
  import audio_pkg::*;
#(
  parameter int NCHAN    = 4,
  parameter int BITDEPTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              div,
  input  logic [NCHAN-1:0]         ch_en,
  input  logic [NCHAN-1:0]         ch_valid,
  input  logic [SAMPLE_W*NCHAN-1:0] ch_sample,
  output logic [NCHAN-1:0]         ch_ready,
  output logic [BITDEPTH-1:0]      pcm,
  output logic                     sample_clock,
  output logic [7:0]               urun_cnt,
  input  logic                     urun_clr
`ifdef AUDIO_MASTER_VOL_EN
  ,
  input  logic [7:0]               master_vol
`endif
);

  localparam int          IDX_W   = $clog2(NCHAN);
  localparam int          ACC_W   = SAMPLE_W + $clog2(NCHAN);
  // The busy sequence COLLECT..STROBE lasts NCHAN+3 cycles, so a period of
  // at least NCHAN+4 clocks guarantees every tick lands in IDLE.
  localparam logic [15:0] MIN_DIV = 16'(NCHAN + 3);

  // ---------------------------------------------------------------------
  // Sample period counter
  // ---------------------------------------------------------------------
  logic [15:0] div_eff;
  logic [15:0] cnt_q;
  logic        cnt_load_q;
  logic        tick;

  assign div_eff = (div < MIN_DIV) ? MIN_DIV : div;
  // The first cycle out of reset loads div; afterwards div is only
  // re-read at a reload, so a div change never disturbs the running period.
  assign tick    = !cnt_load_q && (cnt_q == 16'd0);

  // Period countdown with reload on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its inputs.
    if (!rst_n) begin
      cnt_q      <= 16'd0;
      cnt_load_q <= 1'b1;
    end else if (cnt_load_q || tick) begin
      cnt_q      <= div_eff;
      cnt_load_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------
  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    slot_q;
  logic                last_slot;

  assign last_slot = (slot_q == IDX_W'(NCHAN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a tick is only consumed in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (tick) state_d = ST_COLLECT;
      ST_COLLECT: if (last_slot) state_d = ST_SCALE;
      ST_SCALE:   state_d = ST_OUTPUT;
      ST_OUTPUT:  state_d = ST_STROBE;
      ST_STROBE:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Channel slot decode (en/valid looked at only in the channel's own slot)
  // ---------------------------------------------------------------------
  logic                       in_collect;
  logic                       take;
  logic                       urun_evt;
  logic signed [SAMPLE_W-1:0] cur_sample;
  logic signed [ACC_W-1:0]    cur_ext;

  assign in_collect = (state_q == ST_COLLECT);
  assign cur_sample = ch_sample[int'(slot_q)*SAMPLE_W +: SAMPLE_W];
  assign cur_ext    = ACC_W'(cur_sample);

  // Accept or underrun decision for the channel owning this slot.
  always_comb begin
    take     = 1'b0;
    urun_evt = 1'b0;
    if (in_collect && ch_en[slot_q]) begin
      take     = ch_valid[slot_q];
      urun_evt = !ch_valid[slot_q];
    end
  end

  // FSM outputs: single ready pulse for the accepted slot, DAC strobe.
  always_comb begin
    ch_ready     = '0;
    if (take) ch_ready = NCHAN'(1) << slot_q;
    sample_clock = (state_q == ST_STROBE);
  end

  // ---------------------------------------------------------------------
  // Mix datapath
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAMPLE_W-1:0] sat;
  logic signed [SAMPLE_W-1:0] scaled_d;
  logic signed [SAMPLE_W-1:0] scaled_q;
  logic [BITDEPTH-1:0]        pcm_d;

  audio_sat16 #(
    .ACC_W (ACC_W)
  ) u_sat (
    .acc (acc_q),
    .sat (sat)
  );

`ifdef AUDIO_MASTER_VOL_EN
  logic signed [24:0] vol_prod;

  // Master volume: saturated mix times master_vol/256, rounded toward -inf.
  always_comb begin
    vol_prod = 25'(sat) * 25'($signed({1'b0, master_vol}));
    scaled_d = SAMPLE_W'(vol_prod >>> 8);
  end
`else
  assign scaled_d = sat;
`endif

  // Offset binary: flip the sign bit, keep the top BITDEPTH bits.
  assign pcm_d = BITDEPTH'((scaled_q ^ 16'h8000) >> (SAMPLE_W - BITDEPTH));

  // Slot index, accumulator, scaled mix and the PCM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      acc_q    <= '0;
      scaled_q <= '0;
      pcm      <= BITDEPTH'(midscale(BITDEPTH));
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          slot_q <= '0;
          if (tick) acc_q <= '0;
        end
        ST_COLLECT: begin
          slot_q <= slot_q + IDX_W'(1);
          if (take) acc_q <= acc_q + cur_ext;
        end
        ST_SCALE:  scaled_q <= scaled_d;
        ST_OUTPUT: pcm      <= pcm_d;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Underrun counter: saturating, clear wins but a same-cycle underrun
  // is still counted.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urun_cnt <= 8'd0;
    end else if (urun_clr) begin
      urun_cnt <= urun_evt ? 8'd1 : 8'd0;
    end else if (urun_evt && (urun_cnt != 8'hFF)) begin
      urun_cnt <= urun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Self-checking bench for audio_mix_sched (NCHAN=4, BITDEPTH=12).
// Table-driven mix vectors feed a scoreboard of expected PCM words and
// ready masks; hand-written sequences cover period changes, underrun
// saturation/clear and reset in the middle of COLLECT.
module tb_audio_mix_sched;

  localparam int NCHAN    = 4;
  localparam int BITDEPTH = 12;
  localparam int LIMIT    = 2000;

  logic                 clk;
  logic                 rst_n;
  logic [15:0]          div;
  logic [NCHAN-1:0]     ch_en;
  logic [NCHAN-1:0]     ch_valid;
  logic [16*NCHAN-1:0]  ch_sample;
  logic [NCHAN-1:0]     ch_ready;
  logic [BITDEPTH-1:0]  pcm;
  logic                 sample_clock;
  logic [7:0]           urun_cnt;
  logic                 urun_clr;
`ifdef AUDIO_MASTER_VOL_EN
  logic [7:0]           master_vol;
`endif

  audio_mix_sched #(
    .NCHAN    (NCHAN),
    .BITDEPTH (BITDEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div          (div),
    .ch_en        (ch_en),
    .ch_valid     (ch_valid),
    .ch_sample    (ch_sample),
    .ch_ready     (ch_ready),
    .pcm          (pcm),
    .sample_clock (sample_clock),
    .urun_cnt     (urun_cnt),
    .urun_clr     (urun_clr)
`ifdef AUDIO_MASTER_VOL_EN
    ,
    .master_vol   (master_vol)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  valid;
    logic [63:0] samples;    // {ch3, ch2, ch1, ch0}
    logic [15:0] exp_sat;    // expected saturated 16-bit mix
    logic [3:0]  exp_ready;  // expected set of ready pulses in the period
    logic [7:0]  urun_inc;   // expected underruns per period
  } vec_t;

  typedef struct packed {
    logic [11:0] pcm;
    logic [3:0]  ready;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_urun = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic [3:0] valid,
                              input logic [63:0] samples, input logic [15:0] sat,
                              input logic [3:0] ready, input logic [7:0] inc);
    vec_t v;
    v.en = en; v.valid = valid; v.samples = samples;
    v.exp_sat = sat; v.exp_ready = ready; v.urun_inc = inc;
    return v;
  endfunction

  // Expected DAC code for a saturated mix value.
  function automatic logic [11:0] to_pcm(input logic [15:0] sat_val);
    logic signed [15:0] s;
`ifdef AUDIO_MASTER_VOL_EN
    logic signed [24:0] p;
`endif
    s = sat_val;
`ifdef AUDIO_MASTER_VOL_EN
    p = 25'(s) * 25'($signed({1'b0, master_vol}));
    s = 16'(p >>> 8);
`endif
    return {~s[15], s[14:4]};
  endfunction

  // ---------------------------------------------------------------------
  // Monitor: ready pulse ordering and scoreboard comparison at each strobe
  // ---------------------------------------------------------------------
  logic [3:0] seen;
  int         last_idx;
  logic       prev_sc;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("ready_in_reset", ch_ready, 0);
      seen     = '0;
      last_idx = -1;
      prev_sc  = 1'b0;
    end else begin
      if (ch_ready != 0) begin
        int idx;
        idx = 0;
        for (int b = 0; b < NCHAN; b++) if (ch_ready[b]) idx = b;
        check("ready_onehot", $onehot(ch_ready), 1);
        check("ready_order", (idx > last_idx), 1);
        last_idx = idx;
        seen     = seen | ch_ready;
      end
      if (sample_clock) begin
        check("strobe_width", prev_sc, 0);
        check("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("pcm", pcm, e.pcm);
          check("ready_mask", seen, e.ready);
        end
        seen     = '0;
        last_idx = -1;
      end
      prev_sc = sample_clock;
    end
  end

  // ---------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------
  task automatic apply(input vec_t v);
    ch_en     = v.en;
    ch_valid  = v.valid;
    ch_sample = v.samples;
  endtask

  // Waits for the next strobe; n = clocks since the call.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_clock && n < LIMIT);
    check("strobe_seen", sample_clock, 1);
  endtask

  // One sample period with the currently applied vector.
  task automatic run_period(input vec_t v, output int n);
    sb_q.push_back({to_pcm(v.exp_sat), v.exp_ready});
    wait_strobe(n);
    exp_urun = (exp_urun + int'(v.urun_inc) > 255) ? 255 : exp_urun + int'(v.urun_inc);
    check("urun_cnt", urun_cnt, exp_urun);
  endtask

  // Waits until channel 0 is accepted (slot 0 of COLLECT).
  task automatic wait_slot0();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ch_ready[0] && k < LIMIT);
    check("slot0_seen", ch_ready[0], 1);
  endtask

  vec_t tbl[10];

  initial begin
    int n;
    vec_t v_full, v_urun;

    tbl[0] = mk(4'b1111, 4'b1111, {4{16'h1000}}, 16'h4000, 4'b1111, 8'd0);
    tbl[1] = mk(4'b1111, 4'b1111, {4{16'h7000}}, 16'h7FFF, 4'b1111, 8'd0);
    tbl[2] = mk(4'b1111, 4'b1111, {4{16'h9000}}, 16'h8000, 4'b1111, 8'd0);
    tbl[3] = mk(4'b0101, 4'b1011, {4{16'h0100}}, 16'h0100, 4'b0001, 8'd1);
    tbl[4] = mk(4'b0000, 4'b1111, {4{16'h1234}}, 16'h0000, 4'b0000, 8'd0);
    tbl[5] = mk(4'b1111, 4'b1111, {16'hFFF0, 16'h0010, 16'hFF00, 16'h0123}, 16'h0023, 4'b1111, 8'd0);
    tbl[6] = mk(4'b1111, 4'b0110, {4{16'hF000}}, 16'hE000, 4'b0110, 8'd2);
    tbl[7] = mk(4'b1111, 4'b1111, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 16'h7FFF, 4'b1111, 8'd0);
    tbl[8] = mk(4'b1111, 4'b1111, {16'h0000, 16'h0000, 16'h0001, 16'h7FFF}, 16'h7FFF, 4'b1111, 8'd0);
    tbl[9] = mk(4'b1111, 4'b1111, {16'h0000, 16'h0000, 16'hFFFF, 16'h8000}, 16'h8000, 4'b1111, 8'd0);
    v_full = tbl[0];
    v_urun = tbl[3];

    rst_n     = 1'b0;
    div       = 16'd19;
    ch_en     = '0;
    ch_valid  = '0;
    ch_sample = '0;
    urun_clr  = 1'b0;
`ifdef AUDIO_MASTER_VOL_EN
    master_vol = 8'hFF;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_pcm", pcm, 12'h800);
    check("reset_sample_clock", sample_clock, 0);
    check("reset_ch_ready", ch_ready, 0);
    check("reset_urun", urun_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mix vectors, one period each (inputs change right after a strobe).
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      run_period(tbl[i], n);
    end
    check("period_div19", n, 20);

    // div 19 -> 99: the running period keeps its reload, then 100 clocks.
    apply(v_full);
    div = 16'd99;
    run_period(v_full, n);
    check("div_deferred", n, 20);
    run_period(v_full, n);
    check("period_div99", n, 100);
`ifndef AUDIO_MASTER_VOL_EN
    check("pcm_0x1000x4", pcm, 12'hC00);
`endif

    // div 99 -> 49 mid-period: current period 100, next 50.
    repeat (10) @(posedge clk);
    #1;
    div = 16'd49;
    run_period(v_full, n);
    check("div_change_current", n, 90);
    run_period(v_full, n);
    check("div_change_next", n, 50);

    // div below the minimum clamps to NCHAN+3: period NCHAN+4 = 8 clocks.
    div = 16'd2;
    run_period(v_full, n);
    check("div_min_transition", n, 50);
    for (int i = 0; i < 3; i++) begin
      run_period(v_full, n);
      check("div_min_period", n, 8);
    end

    // Underrun counting and saturation over 300 periods.
    apply(v_urun);
    for (int i = 0; i < 300; i++) run_period(v_urun, n);
    check("urun_saturated", urun_cnt, 255);

    // urun_clr coincident with the slot-2 underrun leaves the count at 1.
    sb_q.push_back({to_pcm(v_urun.exp_sat), v_urun.exp_ready});
    wait_slot0();
    @(posedge clk); #1;                 // slot 1
    @(posedge clk); #1;                 // slot 2 (underrun)
    urun_clr = 1'b1;
    @(posedge clk); #1;
    urun_clr = 1'b0;
    check("urun_clr_coincident", urun_cnt, 1);
    exp_urun = 1;
    wait_strobe(n);
    check("urun_after_clr", urun_cnt, 1);

    // Reset in COLLECT slot 2: partial mix discarded, restart from div.
    apply(v_full);
    div = 16'd99;
    run_period(v_full, n);
    run_period(v_full, n);
    check("period_pre_reset", n, 100);
    wait_slot0();
    @(posedge clk); #1;                 // slot 1
    @(posedge clk); #1;                 // slot 2
    rst_n = 1'b0;
    sb_q.delete();
    exp_urun = 0;
    #1;
    check("midreset_pcm", pcm, 12'h800);
    check("midreset_ready", ch_ready, 0);
    check("midreset_sample_clock", sample_clock, 0);
    check("midreset_urun", urun_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back({to_pcm(v_full.exp_sat), v_full.exp_ready});
    wait_strobe(n);
    check("reset_restart_latency", n, 99 + 1 + NCHAN + 3);

`ifdef AUDIO_MASTER_VOL_EN
    // Master volume 0x80 on a 0x2000 mix halves it: pcm 0x900.
    master_vol = 8'h80;
    apply(mk(4'b0001, 4'b0001, {48'h0, 16'h2000}, 16'h2000, 4'b0001, 8'd0));
    run_period(mk(4'b0001, 4'b0001, {48'h0, 16'h2000}, 16'h2000, 4'b0001, 8'd0), n);
    check("master_vol_pcm", pcm, 12'h900);
`endif

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
